// File: rtl/pingpang_pkg.sv
// Shared definitions for the ping-pong match scheduler, display and rally blocks.
package pingpang_pkg;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERVE_WAIT = 3'd1,
        ST_RALLY      = 3'd2,
        ST_SCORE      = 3'd3,
        ST_GAME_END   = 3'd4,
        ST_MATCH_END  = 3'd5
    } state_t;

    // Player encoding
    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    // Default match rules
    localparam int DEF_POINTS_TO_WIN = 11;
    localparam int DEF_WIN_MARGIN    = 2;
    localparam int DEF_GAMES_TO_WIN  = 3;
    localparam int DEF_SERVE_ROT     = 2;

    // Field widths and the tie at which a long deuce folds back to 10:10
    localparam int SCORE_W   = 5;
    localparam int GAMES_W   = 3;
    localparam int SAT_SCORE = 30;

    // True when the rally winner's new score closes out the game
    function automatic logic game_won(input logic [SCORE_W-1:0] win_score,
                                      input logic [SCORE_W-1:0] lose_score,
                                      input int points_to_win,
                                      input int win_margin);
        return (int'(win_score) >= points_to_win) &&
               ((int'(win_score) - int'(lose_score)) >= win_margin);
    endfunction

endpackage

// File: rtl/pingpang_serve_rot.sv
// Serve rotation: counts points in the current serve turn and flips the server.
module pingpang_serve_rot
    import pingpang_pkg::*;
#(
    parameter int SERVE_ROT = DEF_SERVE_ROT
) (
    input  logic clk,
    input  logic rst,
    input  logic point_pulse,
    input  logic deuce,
    input  logic game_start,
    input  logic start_server,
    output logic server
);

    localparam int ROT_W = $clog2(SERVE_ROT + 1);

    logic [ROT_W-1:0] rot_cnt_r;
    logic [ROT_W-1:0] rot_next_s;
    logic             rot_toggle_s;
    logic             server_r;

    // Count including the point being scored; at deuce every point hands over the serve
    always_comb begin
        rot_next_s   = rot_cnt_r + ROT_W'(1);
        rot_toggle_s = deuce || (rot_next_s == ROT_W'(SERVE_ROT));
    end

    // Server register; a new game loads its first server and restarts the turn count
    always_ff @(posedge clk) begin
        if (rst) begin
            rot_cnt_r <= {ROT_W{1'b0}};
            server_r  <= P1;
        end else if (game_start) begin
            rot_cnt_r <= {ROT_W{1'b0}};
            server_r  <= start_server;
        end else if (point_pulse) begin
            if (rot_toggle_s) begin
                rot_cnt_r <= {ROT_W{1'b0}};
                server_r  <= ~server_r;
            end else begin
                rot_cnt_r <= rot_next_s;
            end
        end
    end

    assign server = server_r;

endmodule

// File: rtl/pingpang_match_sched.sv
// Ping-pong match scheduler: serve permission, scoring, game and match decisions.
module pingpang_match_sched
    import pingpang_pkg::*;
#(
    parameter int POINTS_TO_WIN = DEF_POINTS_TO_WIN,
    parameter int WIN_MARGIN    = DEF_WIN_MARGIN,
    parameter int GAMES_TO_WIN  = DEF_GAMES_TO_WIN,
    parameter int SERVE_ROT     = DEF_SERVE_ROT
) (
    input  logic               HSE,
    input  logic               rst,
    input  logic               play1,
    input  logic               play2,
    input  logic               rally_done,
    input  logic               rally_winner,
    output logic               rally_start,
    output logic               server,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [GAMES_W-1:0] games1,
    output logic [GAMES_W-1:0] games2,
    output logic               match_over,
    output logic               match_winner
);

    state_t             state_r, state_nx;
    logic               key1_r, key2_r;
    logic               press1_s, press2_s;
    logic               first_server_r, first_server_nx;
    logic               winner_r, winner_nx;
    logic [SCORE_W-1:0] score1_r, score1_nx, score2_r, score2_nx;
    logic [SCORE_W-1:0] sum1_s, sum2_s;
    logic [GAMES_W-1:0] games1_r, games1_nx, games2_r, games2_nx;
    logic [GAMES_W-1:0] games_win_s;
    logic               rally_start_r, rally_start_nx;
    logic               match_over_r, match_over_nx;
    logic               match_winner_r, match_winner_nx;
    logic               game_start_s, start_server_s, point_pulse_s, deuce_s;
    logic               pressed_s, sat_s, game_won_s, server_s;

    // Keys are active-low; a press is the first low sample after a high one
    assign press1_s = key1_r & ~play1;
    assign press2_s = key2_r & ~play2;

    pingpang_serve_rot #(
        .SERVE_ROT (SERVE_ROT)
    ) u_serve_rot (
        .clk          (HSE),
        .rst          (rst),
        .point_pulse  (point_pulse_s),
        .deuce        (deuce_s),
        .game_start   (game_start_s),
        .start_server (start_server_s),
        .server       (server_s)
    );

    // Next-state, scoring and handshake decisions
    always_comb begin
        state_nx        = state_r;
        first_server_nx = first_server_r;
        winner_nx       = winner_r;
        score1_nx       = score1_r;
        score2_nx       = score2_r;
        games1_nx       = games1_r;
        games2_nx       = games2_r;
        rally_start_nx  = 1'b0;
        match_over_nx   = match_over_r;
        match_winner_nx = match_winner_r;
        game_start_s    = 1'b0;
        start_server_s  = first_server_r;
        point_pulse_s   = 1'b0;
        pressed_s       = 1'b0;
        sat_s           = 1'b0;
        game_won_s      = 1'b0;
        sum1_s          = score1_r;
        sum2_s          = score2_r;
        games_win_s     = (winner_r == P1) ? games1_r : games2_r;
        deuce_s         = (score1_r >= SCORE_W'(POINTS_TO_WIN - 1)) &&
                          (score2_r >= SCORE_W'(POINTS_TO_WIN - 1));

        case (state_r)
            ST_IDLE: begin
                pressed_s = press1_s | press2_s;
                if (pressed_s) begin
                    first_server_nx = press1_s ? P1 : P2;
                    start_server_s  = press1_s ? P1 : P2;
                    game_start_s    = 1'b1;
                    rally_start_nx  = 1'b1;
                    state_nx        = ST_RALLY;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SERVE_WAIT: begin
                pressed_s = (server_s == P1) ? press1_s : press2_s;
                if (pressed_s) begin
                    rally_start_nx = 1'b1;
                    state_nx       = ST_RALLY;
                end else begin
                    state_nx = ST_SERVE_WAIT;
                end
            end
            ST_RALLY: begin
                if (rally_done) begin
                    winner_nx = rally_winner;
                    state_nx  = ST_SCORE;
                end else begin
                    state_nx = ST_RALLY;
                end
            end
            ST_SCORE: begin
                point_pulse_s = 1'b1;
                if (winner_r == P1) begin
                    sum1_s = score1_r + SCORE_W'(1);
                end else begin
                    sum2_s = score2_r + SCORE_W'(1);
                end
                sat_s     = (sum1_s == SCORE_W'(SAT_SCORE)) && (sum2_s == SCORE_W'(SAT_SCORE));
                score1_nx = sat_s ? SCORE_W'(POINTS_TO_WIN - 1) : sum1_s;
                score2_nx = sat_s ? SCORE_W'(POINTS_TO_WIN - 1) : sum2_s;
                game_won_s = (winner_r == P1) ?
                             game_won(score1_nx, score2_nx, POINTS_TO_WIN, WIN_MARGIN) :
                             game_won(score2_nx, score1_nx, POINTS_TO_WIN, WIN_MARGIN);
                games_win_s = ((winner_r == P1) ? games1_r : games2_r) + GAMES_W'(1);
                if (game_won_s) begin
                    if (winner_r == P1) begin
                        games1_nx = games_win_s;
                    end else begin
                        games2_nx = games_win_s;
                    end
                    if (games_win_s == GAMES_W'(GAMES_TO_WIN)) begin
                        match_over_nx   = 1'b1;
                        match_winner_nx = winner_r;
                        state_nx        = ST_MATCH_END;
                    end else begin
                        state_nx = ST_GAME_END;
                    end
                end else begin
                    state_nx = ST_SERVE_WAIT;
                end
            end
            ST_GAME_END: begin
                // The next game opens with the other player from last game's opener
                pressed_s = (first_server_r == P1) ? press2_s : press1_s;
                if (pressed_s) begin
                    first_server_nx = ~first_server_r;
                    start_server_s  = ~first_server_r;
                    game_start_s    = 1'b1;
                    score1_nx       = {SCORE_W{1'b0}};
                    score2_nx       = {SCORE_W{1'b0}};
                    rally_start_nx  = 1'b1;
                    state_nx        = ST_RALLY;
                end else begin
                    state_nx = ST_GAME_END;
                end
            end
            ST_MATCH_END: begin
                state_nx = ST_MATCH_END;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, key history and scoreboard registers
    always_ff @(posedge HSE) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            key1_r         <= 1'b1;
            key2_r         <= 1'b1;
            first_server_r <= P1;
            winner_r       <= P1;
            score1_r       <= {SCORE_W{1'b0}};
            score2_r       <= {SCORE_W{1'b0}};
            games1_r       <= {GAMES_W{1'b0}};
            games2_r       <= {GAMES_W{1'b0}};
            rally_start_r  <= 1'b0;
            match_over_r   <= 1'b0;
            match_winner_r <= 1'b0;
        end else begin
            state_r        <= state_nx;
            key1_r         <= play1;
            key2_r         <= play2;
            first_server_r <= first_server_nx;
            winner_r       <= winner_nx;
            score1_r       <= score1_nx;
            score2_r       <= score2_nx;
            games1_r       <= games1_nx;
            games2_r       <= games2_nx;
            rally_start_r  <= rally_start_nx;
            match_over_r   <= match_over_nx;
            match_winner_r <= match_winner_nx;
        end
    end

    assign rally_start  = rally_start_r;
    assign server       = server_s;
    assign score1       = score1_r;
    assign score2       = score2_r;
    assign games1       = games1_r;
    assign games2       = games2_r;
    assign match_over   = match_over_r;
    assign match_winner = match_winner_r;

endmodule

// File: tb/tb_pingpang_match_sched.sv
// Self-checking bench for pingpang_match_sched: directed scenarios plus random play.
module tb_pingpang_match_sched;

    logic       HSE = 1'b0;
    logic       rst, play1, play2, rally_done, rally_winner;
    logic       rally_start, server, match_over, match_winner;
    logic [4:0] score1, score2;
    logic [2:0] games1, games2;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    // Model phases of a match
    localparam int PH_IDLE = 0, PH_WAIT = 1, PH_RALLY = 2, PH_SCORE = 3, PH_GAME_END = 4, PH_OVER = 5;
    // Default rules: 11 points, margin 2, 3 games, 2 serves per turn; deuce from 20 points played
    localparam int PTW = 11, MARGIN = 2, GTW = 3, ROT = 2, DEUCE_PTS = 20;

    int m_phase, m_s1, m_s2, m_g1, m_g2, m_first, m_win, m_played;
    bit m_k1, m_k2, m_due;
    int e_rs, e_srv, e_mo, e_mw;

    always #5 HSE = ~HSE;

    pingpang_match_sched dut (
        .HSE          (HSE),
        .rst          (rst),
        .play1        (play1),
        .play2        (play2),
        .rally_done   (rally_done),
        .rally_winner (rally_winner),
        .rally_start  (rally_start),
        .server       (server),
        .score1       (score1),
        .score2       (score2),
        .games1       (games1),
        .games2       (games2),
        .match_over   (match_over),
        .match_winner (match_winner)
    );

    // Server after `played` points of a game: turns of ROT points, then every point at deuce
    function automatic int serve_of(int first, int played);
        if (played < DEUCE_PTS) return first ^ ((played / ROT) % 2);
        return first ^ (played % 2);
    endfunction

    task automatic start_game();
        m_s1 = 0; m_s2 = 0; m_played = 0;
        e_srv = m_first; e_rs = 1; m_phase = PH_RALLY;
    endtask

    task automatic score_point();
        int w, l, g;
        if (m_win == 0) m_s1++; else m_s2++;
        m_played++;
        if (m_s1 == 30 && m_s2 == 30) begin m_s1 = PTW - 1; m_s2 = PTW - 1; end
        e_srv = serve_of(m_first, m_played);
        w = (m_win == 0) ? m_s1 : m_s2;
        l = (m_win == 0) ? m_s2 : m_s1;
        if (w >= PTW && w - l >= MARGIN) begin
            if (m_win == 0) m_g1++; else m_g2++;
            g = (m_win == 0) ? m_g1 : m_g2;
            if (g == GTW) begin e_mo = 1; e_mw = m_win; m_phase = PH_OVER; end
            else m_phase = PH_GAME_END;
        end else begin
            m_phase = PH_WAIT;
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT sees at that edge
    task automatic model_step();
        bit pr1, pr2;
        pr1 = m_k1 && !play1;
        pr2 = m_k2 && !play2;
        if (rst) begin
            m_phase = PH_IDLE; m_s1 = 0; m_s2 = 0; m_g1 = 0; m_g2 = 0; m_first = 0;
            m_win = 0; m_played = 0; m_k1 = 1; m_k2 = 1; m_due = 0;
            e_rs = 0; e_srv = 0; e_mo = 0; e_mw = 0;
            return;
        end
        m_k1 = play1; m_k2 = play2;
        e_rs = 0;
        if (m_due) begin
            m_due = 0;
            score_point();
        end else if (m_phase == PH_IDLE) begin
            if (pr1 || pr2) begin m_first = pr1 ? 0 : 1; start_game(); end
        end else if (m_phase == PH_WAIT) begin
            if ((e_srv == 0 && pr1) || (e_srv == 1 && pr2)) begin e_rs = 1; m_phase = PH_RALLY; end
        end else if (m_phase == PH_RALLY) begin
            if (rally_done) begin m_due = 1; m_win = rally_winner ? 1 : 0; m_phase = PH_SCORE; end
        end else if (m_phase == PH_GAME_END) begin
            if ((m_first == 0 && pr2) || (m_first == 1 && pr1)) begin m_first = 1 - m_first; start_game(); end
        end
    endtask

    task automatic tick();
        @(posedge HSE);
        model_step();
        #1;
    endtask

    task automatic lit(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; play1 = 1'b1; play2 = 1'b1; rally_done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic press(int pl);
        if (pl == 0) play1 = 1'b0; else play2 = 1'b0;
        tick();
        play1 = 1'b1; play2 = 1'b1;
        tick();
    endtask

    task automatic rally(int w);
        rally_done = 1'b1; rally_winner = (w != 0);
        tick();
        rally_done = 1'b0;
        tick();
        tick();
    endtask

    function automatic int next_presser();
        return (m_phase == PH_GAME_END) ? 1 - m_first : e_srv;
    endfunction

    task automatic play_point(int w);
        press(next_presser());
        rally(w);
    endtask

    // Every-cycle comparison of all outputs against the model
    initial begin
        logic [19:0] act, exp;
        forever begin
            @(negedge HSE);
            if (chk_en) begin
                act = {rally_start, server, score1, score2, games1, games2, match_over, match_winner};
                exp = {1'(e_rs), 1'(e_srv), 5'(m_s1), 5'(m_s2), 3'(m_g1), 3'(m_g2), 1'(e_mo), 1'(e_mw)};
                vectors++;
                if (act !== exp) begin
                    miscompares++;
                    $display("FAIL cycle_check t=%0t got rs=%b srv=%b s=%0d:%0d g=%0d:%0d mo=%b mw=%b expected rs=%0d srv=%0d s=%0d:%0d g=%0d:%0d mo=%0d mw=%0d",
                             $time, rally_start, server, score1, score2, games1, games2, match_over, match_winner,
                             e_rs, e_srv, m_s1, m_s2, m_g1, m_g2, e_mo, e_mw);
                end
            end
        end
    end

    initial begin
        int rot_exp[4] = '{0, 1, 1, 0};
        rst = 1'b1; play1 = 1'b1; play2 = 1'b1; rally_done = 1'b0; rally_winner = 1'b0;
        tick();
        chk_en = 1'b1;
        @(negedge HSE);
        lit("reset_score1", score1, 0);
        lit("reset_games2", games2, 0);
        lit("reset_rally_start", rally_start, 0);
        lit("reset_match_over", match_over, 0);
        rst = 1'b0;

        // Serve choice by player 2
        play2 = 1'b0;
        tick();
        @(negedge HSE);
        lit("serve_p2_start", rally_start, 1);
        lit("serve_p2_server", server, 1);
        play2 = 1'b1;
        tick();
        @(negedge HSE);
        lit("start_single_cycle", rally_start, 0);

        // Simultaneous presses go to player 1
        do_reset();
        play1 = 1'b0; play2 = 1'b0;
        tick();
        @(negedge HSE);
        lit("simul_start", rally_start, 1);
        lit("simul_server", server, 0);
        play1 = 1'b1; play2 = 1'b1;
        tick();

        // Rotation: P1 wins four points, non-server press ignored
        for (int k = 0; k < 4; k++) begin
            if (k > 0) press(next_presser());
            rally(0);
            @(negedge HSE);
            lit($sformatf("rot_point%0d_server", k + 1), server, rot_exp[k]);
            if (k == 1) begin
                play1 = 1'b0;
                tick();
                @(negedge HSE);
                lit("nonserver_press", rally_start, 0);
                play1 = 1'b1;
                tick();
            end
        end

        // Normal game to 10:9, then P1 closes 11:9
        for (int i = 0; i < 15; i++) play_point((i < 9) ? 1 : 0);
        @(negedge HSE);
        lit("pre_game_s1", score1, 10);
        lit("pre_game_s2", score2, 9);
        press(next_presser());
        rally_done = 1'b1; rally_winner = 1'b0;
        tick();
        rally_done = 1'b0;
        @(negedge HSE);
        lit("game_in_score_cycle", games1, 0);
        tick();
        @(negedge HSE);
        lit("game1_won", games1, 1);
        lit("game1_s1", score1, 11);
        lit("game1_s2", score2, 9);
        repeat (3) tick();
        play1 = 1'b0;
        tick();
        @(negedge HSE);
        lit("game_end_wrong_key", rally_start, 0);
        lit("game_end_hold_s1", score1, 11);
        play1 = 1'b1;
        tick();
        play2 = 1'b0;
        tick();
        @(negedge HSE);
        lit("game2_start", rally_start, 1);
        lit("game2_clear_s1", score1, 0);
        lit("game2_clear_s2", score2, 0);
        lit("game2_server", server, 1);
        play2 = 1'b1;
        tick();

        // Deuce: 10:10 then P1 takes two points
        for (int i = 0; i < 20; i++) begin
            if (i > 0) press(next_presser());
            rally(i % 2);
        end
        @(negedge HSE);
        lit("deuce_1010_server", server, 1);
        play_point(0);
        @(negedge HSE);
        lit("deuce_1110_server", server, 0);
        lit("deuce_1110_games", games1, 1);
        play_point(0);
        @(negedge HSE);
        lit("deuce_1210_games", games1, 2);
        lit("deuce_1210_server", server, 1);

        // Saturation: 10:10 up to 30:29, then P2 ties back to 10:10
        for (int i = 0; i < 20; i++) play_point(i % 2);
        for (int i = 0; i < 39; i++) play_point(i % 2);
        @(negedge HSE);
        lit("sat_3029_s1", score1, 30);
        lit("sat_3029_s2", score2, 29);
        play_point(1);
        @(negedge HSE);
        lit("sat_fold_s1", score1, 10);
        lit("sat_fold_s2", score2, 10);
        play_point(1);
        play_point(1);
        @(negedge HSE);
        lit("sat_game_p2", games2, 1);

        // Match end: P2 wins three straight games, then everything is ignored
        do_reset();
        for (int i = 0; i < 33; i++) play_point(1);
        @(negedge HSE);
        lit("match_games2", games2, 3);
        lit("match_over", match_over, 1);
        lit("match_winner", match_winner, 1);
        press(0);
        press(1);
        rally(0);
        @(negedge HSE);
        lit("match_frozen_s2", score2, 11);
        lit("match_frozen_over", match_over, 1);

        // Reset during a rally drops the in-flight rally_done
        do_reset();
        for (int i = 0; i < 3; i++) play_point(0);
        press(next_presser());
        rst = 1'b1; rally_done = 1'b1; rally_winner = 1'b0;
        tick();
        rst = 1'b0; rally_done = 1'b0;
        @(negedge HSE);
        lit("rst_mid_s1", score1, 0);
        lit("rst_mid_server", server, 0);
        lit("rst_mid_start", rally_start, 0);
        repeat (4) tick();

        // Random play against the model
        do_reset();
        for (int n = 0; n < 6000; n++) begin
            play1 = ($urandom_range(0, 3) != 0);
            play2 = ($urandom_range(0, 3) != 0);
            rally_done = ($urandom_range(0, 3) == 0);
            rally_winner = ($urandom_range(0, 1) == 1);
            rst = ((m_phase == PH_OVER) && ($urandom_range(0, 19) == 0)) || ($urandom_range(0, 1499) == 0);
            tick();
        end
        rst = 1'b0; play1 = 1'b1; play2 = 1'b1; rally_done = 1'b0;
        tick();
        @(negedge HSE);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
